nios2_keypad_scanner: RTL and testbench

//  Scans a 4x4 active-low key matrix through the 8-bit bidirectional KEY pin bus.

---
 rtl/nios2_keypad_scanner_if.sv | 21 ++
 rtl/nios2_keypad_scanner.sv | 236 +++++++++++++++++++++++
 tb/tb_nios2_keypad_scanner.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/nios2_keypad_scanner_if.sv
// Avalon-MM slave bus and level interrupt of the keypad scanner.
// The NIOS2 side takes the master modport, the scanner the slave modport.
interface nios2_keypad_scanner_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        read_n;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport master (
        output address, chipselect, read_n, write_n, writedata,
        input  readdata, irq
    );

    modport slave (
        input  address, chipselect, read_n, write_n, writedata,
        output readdata, irq
    );
endinterface

// File: rtl/nios2_keypad_scanner.sv
// 4x4 keypad scanner: row sequencing, full-image debounce, key-code FIFO.
// Registers: 0 DATA (pop), 1 STATUS, 2 CONTROL, 3 CLEAR overflow.
module nios2_keypad_scanner #(
    parameter int SETTLE_CYC = 64,
    parameter int DEB_SCANS  = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    nios2_keypad_scanner_if.slave        av,
    inout  wire  [7:0]                   bidir_port
);
    localparam int SW = $clog2(SETTLE_CYC);
    localparam int DW = $clog2(DEB_SCANS + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_SETTLE,
        S_SAMPLE,
        S_END
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    row_q, row_d;
    logic [SW-1:0] settle_q, settle_d;
    logic [3:0]    col_s1_q, col_s2_q;
    logic [15:0]   snap_q, snap_d;
    logic [15:0]   prev_q, prev_d;
    logic [15:0]   deb_q, deb_d;
    logic [DW-1:0] stable_q, stable_d;
    logic [15:0]   newp, lowest;
    logic          push;
    logic [3:0]    push_code;

    logic [3:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wp_q, rp_q;
    logic [CW-1:0] cnt_q;
    logic          ovf_q;
    logic          enable_q, irq_en_q;
    logic [31:0]   rdata_q, rdata_d;
    logic          irq_q;

    logic          valid, full, pop, do_push;
    logic          rd_data, wr_ctrl, wr_clr;
    logic [3:0]    row_drv;
    logic          unused_wd;

    assign unused_wd = ^av.writedata[31:2];

    assign rd_data = av.chipselect & ~av.read_n  & (av.address == 2'd0);
    assign wr_ctrl = av.chipselect & ~av.write_n & (av.address == 2'd2);
    assign wr_clr  = av.chipselect & ~av.write_n & (av.address == 2'd3);

    assign valid   = (cnt_q != '0);
    assign full    = (cnt_q == CW'(FIFO_DEPTH));
    assign pop     = rd_data & valid;
    assign do_push = push & (~full | pop);

    // Open-drain row drive; reset releases the row without waiting for a clock.
    always_comb begin
        row_drv = 4'b0000;
        if (!reset && (state_q == S_DRIVE || state_q == S_SETTLE ||
                       state_q == S_SAMPLE))
            row_drv[row_q] = 1'b1;
    end

    for (genvar i = 0; i < 4; i++) begin : g_row
        assign bidir_port[i] = row_drv[i] ? 1'b0 : 1'bz;
    end

    // Two-flop synchroniser on the column inputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_s1_q <= 4'hF;
            col_s2_q <= 4'hF;
        end else begin
            col_s1_q <= bidir_port[7:4];
            col_s2_q <= col_s1_q;
        end
    end

    // Scan sequencer next state; dropping enable always wins.
    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        settle_d = settle_q;
        snap_d   = snap_q;
        unique case (state_q)
            S_IDLE: begin
                row_d = 2'd0;
                if (enable_q) state_d = S_DRIVE;
            end
            S_DRIVE: begin
                settle_d = '0;
                state_d  = S_SETTLE;
            end
            S_SETTLE: begin
                settle_d = settle_q + 1'b1;
                if (settle_q == SW'(SETTLE_CYC - 1)) state_d = S_SAMPLE;
            end
            S_SAMPLE: begin
                snap_d[{row_q, 2'b00} +: 4] = ~col_s2_q;
                if (row_q == 2'd3) begin
                    state_d = S_END;
                end else begin
                    row_d   = row_q + 1'b1;
                    state_d = S_DRIVE;
                end
            end
            S_END: begin
                row_d   = 2'd0;
                state_d = S_DRIVE;
            end
            default: state_d = S_IDLE;
        endcase
        if (!enable_q) begin
            state_d = S_IDLE;
            row_d   = 2'd0;
        end
    end

    // Sequencer registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            row_q    <= 2'd0;
            settle_q <= '0;
            snap_q   <= '0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            settle_q <= settle_d;
            snap_q   <= snap_d;
        end
    end

    // Debounce at end of scan: releases all at once, presses lowest-first.
    always_comb begin
        prev_d    = prev_q;
        deb_d     = deb_q;
        stable_d  = stable_q;
        push      = 1'b0;
        push_code = 4'h0;
        newp      = ~deb_q & snap_q;
        lowest    = newp & (~newp + 16'd1);
        if (!enable_q) begin
            deb_d    = '0;
            stable_d = '0;
        end else if (state_q == S_END) begin
            if (snap_q != prev_q)
                stable_d = DW'(1);
            else if (stable_q != DW'(DEB_SCANS))
                stable_d = stable_q + 1'b1;
            prev_d = snap_q;
            if (stable_d == DW'(DEB_SCANS)) begin
                deb_d = (deb_q & snap_q) | lowest;
                push  = |newp;
                for (int i = 15; i >= 0; i--)
                    if (newp[i]) push_code = 4'(i);
            end
        end
    end

    // Debounce registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q   <= '0;
            deb_q    <= '0;
            stable_q <= '0;
        end else begin
            prev_q   <= prev_d;
            deb_q    <= deb_d;
            stable_q <= stable_d;
        end
    end

    // Key-code FIFO; a pop frees room for a same-cycle push when full.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 4'h0;
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            if (do_push) begin
                mem_q[wp_q] <= push_code;
                wp_q        <= wp_q + 1'b1;
            end
            if (pop) rp_q <= rp_q + 1'b1;
            cnt_q <= cnt_q + CW'(do_push) - CW'(pop);
            if (push && !do_push) ovf_q <= 1'b1;
            else if (wr_clr)      ovf_q <= 1'b0;
        end
    end

    // Control register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enable_q <= 1'b0;
            irq_en_q <= 1'b0;
        end else if (wr_ctrl) begin
            enable_q <= av.writedata[0];
            irq_en_q <= av.writedata[1];
        end
    end

    // Read mux; DATA presents the head before the pop takes effect.
    always_comb begin
        rdata_d = '0;
        unique case (av.address)
            2'd0: rdata_d = {23'b0, valid, 4'b0,
                             valid ? mem_q[rp_q] : 4'h0};
            2'd1: rdata_d[CW:0] = {ovf_q, cnt_q};
            2'd2: rdata_d[1:0]  = {irq_en_q, enable_q};
            default: rdata_d = '0;
        endcase
    end

    // Registered read data and interrupt.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_q <= '0;
            irq_q   <= 1'b0;
        end else begin
            rdata_q <= rdata_d;
            irq_q   <= irq_en_q & (valid | ovf_q);
        end
    end

    assign av.readdata = rdata_q;
    assign av.irq      = irq_q;
endmodule

// File: tb/tb_nios2_keypad_scanner.sv
// Directed bench for the keypad scanner with an open-drain key-matrix model.
// Keys are applied at scan start, detected from the falling edge of row 0.
module tb_nios2_keypad_scanner;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    nios2_keypad_scanner_if bus ();
    wire [7:0] kp;

    logic [15:0] keys = '0;
    logic [3:0]  col_low = '0;
    logic [31:0] rd;
    int          n_assert = 0;
    int          n_fail = 0;
    int          viol = 0;
    int          lows;

    for (genvar i = 0; i < 8; i++) begin : g_pu
        pullup pu (kp[i]);
    end

    for (genvar c = 0; c < 4; c++) begin : g_col
        assign kp[4+c] = col_low[c] ? 1'b0 : 1'bz;
    end

    nios2_keypad_scanner #(
        .SETTLE_CYC (4),
        .DEB_SCANS  (8),
        .FIFO_DEPTH (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .av         (bus),
        .bidir_port (kp)
    );

    // Key matrix: a pressed key shorts its column to a row pulled low.
    always @(negedge clk) begin
        logic [3:0] cl;
        cl = 4'b0000;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && kp[r] == 1'b0) cl[c] = 1'b1;
        col_low <= cl;
    end

    // At most one row may be pulled low at a time.
    always @(negedge clk) begin
        logic [3:0] low;
        low = ~kp[3:0];
        if (!reset && $countones(low) > 1) viol++;
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: observed no end expected finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.address    = a;
        bus.chipselect = 1'b1;
        bus.read_n     = 1'b0;
        @(negedge clk);
        d = bus.readdata;
        bus.chipselect = 1'b0;
        bus.read_n     = 1'b1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.address    = a;
        bus.writedata  = d;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic wait_scans(input int n);
        int budget;
        for (int k = 0; k < n; k++) begin
            budget = 0;
            while (kp[0] !== 1'b1 && budget < 200) begin
                @(negedge clk);
                budget++;
            end
            while (kp[0] !== 1'b0 && budget < 200) begin
                @(negedge clk);
                budget++;
            end
            if (budget >= 200) begin
                n_assert++;
                n_fail++;
                $error("FAIL scan_timeout: observed %0d cycles expected <200",
                       budget);
                k = n;
            end
        end
    endtask

    initial begin
        bus.address    = 2'd0;
        bus.chipselect = 1'b0;
        bus.read_n     = 1'b1;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_readdata", bus.readdata, 32'h0);
        check("rst_irq", {31'b0, bus.irq}, 32'h0);
        check("rst_rows", {28'b0, kp[3:0]}, 32'hF);
        reset = 1'b0;
        bus_read(2'd2, rd); check("rst_control", rd, 32'h0);
        bus_read(2'd1, rd); check("rst_status", rd, 32'h0);
        bus_read(2'd0, rd); check("rst_data", rd, 32'h0);
        repeat (20) @(negedge clk);
        check("idle_rows", {28'b0, kp[3:0]}, 32'hF);

        // 1: key 6 held clean
        bus_write(2'd2, 32'h1);
        wait_scans(1);
        keys = 16'h0040;
        wait_scans(7);
        bus_read(2'd1, rd); check("t1_early", rd, 32'h0);
        wait_scans(1);
        bus_read(2'd1, rd); check("t1_count", rd, 32'h1);
        bus_read(2'd0, rd); check("t1_data", rd, 32'h106);
        bus_read(2'd0, rd); check("t1_empty", rd, 32'h0);
        wait_scans(10);
        bus_read(2'd1, rd); check("t1_held", rd, 32'h0);
        keys = '0;
        wait_scans(10);

        // 2: key 9 bouncing, then steady
        for (int b = 0; b < 2; b++) begin
            keys = 16'h0200;
            wait_scans(3);
            keys = '0;
            wait_scans(3);
        end
        bus_read(2'd1, rd); check("t2_bounce", rd, 32'h0);
        wait_scans(1);
        keys = 16'h0200;
        wait_scans(7);
        bus_read(2'd1, rd); check("t2_early", rd, 32'h0);
        wait_scans(1);
        bus_read(2'd1, rd); check("t2_count", rd, 32'h1);
        bus_read(2'd0, rd); check("t2_data", rd, 32'h109);
        bus_read(2'd0, rd); check("t2_empty", rd, 32'h0);
        keys = '0;
        wait_scans(10);

        // 3: keys 3 and 12 together
        keys = 16'h1008;
        wait_scans(8);
        bus_read(2'd1, rd); check("t3_count1", rd, 32'h1);
        wait_scans(1);
        bus_read(2'd1, rd); check("t3_count2", rd, 32'h2);
        bus_read(2'd0, rd); check("t3_first", rd, 32'h103);
        bus_read(2'd0, rd); check("t3_second", rd, 32'h10C);
        bus_read(2'd0, rd); check("t3_empty", rd, 32'h0);
        keys = '0;
        wait_scans(10);

        // 4: five presses into a four-deep FIFO
        bus_write(2'd2, 32'h3);
        wait_scans(1);
        keys = 16'h0037;
        wait_scans(13);
        bus_read(2'd1, rd); check("t4_status", rd, 32'hC);
        check("t4_irq", {31'b0, bus.irq}, 32'h1);
        bus_write(2'd3, 32'hFFFF_FFFF);
        bus_read(2'd1, rd); check("t4_cleared", rd, 32'h4);
        check("t4_irq_cnt", {31'b0, bus.irq}, 32'h1);
        bus_read(2'd0, rd); check("t4_d0", rd, 32'h100);
        bus_read(2'd0, rd); check("t4_d1", rd, 32'h101);
        bus_read(2'd0, rd); check("t4_d2", rd, 32'h102);
        bus_read(2'd0, rd); check("t4_d4", rd, 32'h104);
        repeat (2) @(negedge clk);
        check("t4_irq_low", {31'b0, bus.irq}, 32'h0);
        bus_read(2'd1, rd); check("t4_drained", rd, 32'h0);
        keys = '0;
        wait_scans(10);

        // 5: disable mid-SETTLE keeps the queue
        keys = 16'h0080;
        wait_scans(8);
        bus_read(2'd1, rd); check("t5_count", rd, 32'h1);
        wait_scans(1);
        @(negedge clk);
        bus_write(2'd2, 32'h2);
        @(negedge clk);
        check("t5_release", {28'b0, kp[3:0]}, 32'hF);
        lows = 0;
        repeat (60) begin
            @(negedge clk);
            if (kp[3:0] != 4'hF) lows++;
        end
        check("t5_idle", lows, 32'h0);
        bus_read(2'd1, rd); check("t5_kept", rd, 32'h1);
        bus_read(2'd2, rd); check("t5_control", rd, 32'h2);
        check("t5_irq", {31'b0, bus.irq}, 32'h1);
        bus_write(2'd2, 32'h3);
        wait_scans(1);
        wait_scans(7);
        bus_read(2'd1, rd); check("t5_reacq_early", rd, 32'h1);
        wait_scans(1);
        bus_read(2'd1, rd); check("t5_reacq", rd, 32'h2);
        bus_read(2'd0, rd); check("t5_data", rd, 32'h107);

        // 6: reset mid-scan releases rows at once
        wait_scans(1);
        @(negedge clk);
        check("t6_driven", {31'b0, kp[0]}, 32'h0);
        #2 reset = 1'b1;
        #1;
        check("t6_async_rows", {28'b0, kp[3:0]}, 32'hF);
        check("t6_readdata", bus.readdata, 32'h0);
        check("t6_irq", {31'b0, bus.irq}, 32'h0);
        repeat (3) @(negedge clk);
        check("t6_rows_held", {28'b0, kp[3:0]}, 32'hF);
        reset = 1'b0;
        bus_read(2'd1, rd); check("t6_status", rd, 32'h0);
        bus_read(2'd2, rd); check("t6_control", rd, 32'h0);
        bus_read(2'd0, rd); check("t6_data", rd, 32'h0);
        check("pin_onehot", viol, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end
endmodule
